// File: rtl/ascon_pack_pkg.sv
// Shared constants and types for the Ascon-128 datapath feeders.
// Holds the rate/padding constants and the packer state encoding.
package ascon_pack;

  localparam int unsigned ASCON_RATE_BYTES = 8;
  localparam logic [7:0]  ASCON_PAD_BYTE   = 8'h80;

  typedef enum logic [1:0] {
    PK_FILL,
    PK_OUT,
    PK_PAD
  } packer_state_t;

endpackage

// File: rtl/ascon_pad_insert.sv
// Combinational Ascon padding: keeps lanes below count_i, writes the pad byte at
// lane count_i and zeroes every later lane. Lane 0 is bits [63:56].
module ascon_pad_insert
  import ascon_pack::*;
#(
  parameter logic [7:0] PAD_BYTE = ASCON_PAD_BYTE
) (
  input  logic [63:0] buffer_i,
  input  logic [2:0]  count_i,
  output logic [63:0] padded_o
);

  always_comb begin
    padded_o = '0;
    for (int unsigned i = 0; i < ASCON_RATE_BYTES; i++) begin
      if (i < 32'(count_i)) begin
        padded_o[63-8*i -: 8] = buffer_i[63-8*i -: 8];
      end else if (i == 32'(count_i)) begin
        padded_o[63-8*i -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/ascon_data_packer.sv
// Packs a byte stream big-endian into 64-bit Ascon rate blocks, applies 0x80
// padding and reports the message byte count of each block.
module ascon_data_packer
  import ascon_pack::*;
#(
  parameter int unsigned RATE_BYTES = ASCON_RATE_BYTES,
  parameter logic [7:0]  PAD_BYTE   = ASCON_PAD_BYTE
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  input  logic        empty_i,
  output logic        byte_ready_o,
  output logic [63:0] block_o,
  output logic        block_valid_o,
  output logic        block_last_o,
  output logic [3:0]  block_nbytes_o,
  input  logic        block_ready_i
);

  localparam logic [3:0]  FULL_NBYTES = 4'(RATE_BYTES);
  localparam logic [63:0] PAD_BLOCK   = {PAD_BYTE, 56'h0};

  packer_state_t state_q;
  logic [2:0]    count_q;
  logic [63:0]   buf_q;
  logic [63:0]   block_q;
  logic          last_q;
  logic [3:0]    nbytes_q;
  logic          pad_pending_q;

  logic [63:0]   buf_wr;
  logic [63:0]   buf_padded;
  logic [2:0]    count_inc;

  assign count_inc = count_q + 3'd1;

  always_comb begin
    buf_wr = buf_q;
    buf_wr[6'd63 - {count_q, 3'b000} -: 8] = byte_i;
  end

  // Pad goes right after the byte being written this cycle.
  ascon_pad_insert #(
    .PAD_BYTE (PAD_BYTE)
  ) u_pad_insert (
    .buffer_i (buf_wr),
    .count_i  (count_inc),
    .padded_o (buf_padded)
  );

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state_q       <= PK_FILL;
      count_q       <= '0;
      buf_q         <= '0;
      block_q       <= '0;
      last_q        <= 1'b0;
      nbytes_q      <= '0;
      pad_pending_q <= 1'b0;
    end else begin
      unique case (state_q)
        PK_FILL: begin
          if (byte_valid_i) begin
            if (count_q == 3'd7) begin
              // Full block; a last byte here needs a separate all-pad block.
              block_q       <= buf_wr;
              last_q        <= 1'b0;
              nbytes_q      <= FULL_NBYTES;
              pad_pending_q <= byte_last_i;
              buf_q         <= '0;
              count_q       <= '0;
              state_q       <= PK_OUT;
            end else if (byte_last_i) begin
              block_q  <= buf_padded;
              last_q   <= 1'b1;
              nbytes_q <= {1'b0, count_inc};
              buf_q    <= '0;
              count_q  <= '0;
              state_q  <= PK_OUT;
            end else begin
              buf_q   <= buf_wr;
              count_q <= count_inc;
            end
          end else if (empty_i && (count_q == 3'd0)) begin
            block_q  <= PAD_BLOCK;
            last_q   <= 1'b1;
            nbytes_q <= '0;
            state_q  <= PK_OUT;
          end
        end
        PK_OUT: begin
          if (block_ready_i) begin
            if (pad_pending_q) begin
              pad_pending_q <= 1'b0;
              block_q       <= PAD_BLOCK;
              last_q        <= 1'b1;
              nbytes_q      <= '0;
              state_q       <= PK_PAD;
            end else begin
              block_q  <= '0;
              last_q   <= 1'b0;
              nbytes_q <= '0;
              state_q  <= PK_FILL;
            end
          end
        end
        PK_PAD: begin
          if (block_ready_i) begin
            block_q  <= '0;
            last_q   <= 1'b0;
            nbytes_q <= '0;
            state_q  <= PK_FILL;
          end
        end
        default: state_q <= PK_FILL;
      endcase
    end
  end

  assign byte_ready_o   = (state_q == PK_FILL);
  assign block_valid_o  = (state_q != PK_FILL);
  assign block_o        = block_q;
  assign block_last_o   = last_q;
  assign block_nbytes_o = nbytes_q;

endmodule

// File: doc/ascon_data_packer.md
Name: ascon_data_packer

Overview:
- Upstream feeder for the Ascon-128 core.
- Accepts a byte stream (valid/ready, last flag) and packs it big-endian into 64-bit rate blocks.
- Applies Ascon padding (0x80 then zeros) and presents blocks through a valid/ready handshake; the core's control converts this to data_valid_i/data_i.
- Reports the count of message bytes in the final block so the partial ciphertext can be truncated downstream.

Parameters:
- RATE_BYTES, 8, bytes per rate block (fixed for Ascon-128; block width = 8*RATE_BYTES).
- PAD_BYTE, 8'h80, padding byte inserted after the last message byte.

Ports:
- clock_i  in  1  single system clock, rising edge.
- resetb_i  in  1  synchronous, active-high reset (asserted = 1, sampled on clock_i edge).
- byte_i  in  8  message byte.
- byte_valid_i  in  1  byte_i valid.
- byte_last_i  in  1  qualifies the final byte of the message.
- empty_i  in  1  one-cycle pulse: zero-length message.
- byte_ready_o  out  1  packer accepts a byte this cycle.
- block_o  out  64  packed block; first byte in [63:56].
- block_valid_o  out  1  block_o valid.
- block_last_o  out  1  final (padded) block of the message.
- block_nbytes_o  out  4  message bytes in block_o, 0..8.
- block_ready_i  in  1  consumer takes block this cycle.

Behaviour:
- Reset (resetb_i=1 at edge):
  - State=FILL, count=0, buffer=0.
  - block_valid_o=0, block_last_o=0, block_nbytes_o=0, block_o=0, byte_ready_o=1 (from the next cycle).
  - Reset mid-operation discards any partial buffer or pending block. block_valid_o is low in the cycle after the reset edge, regardless of block_ready_i.
- Handshakes:
  - Byte transfer = byte_valid_i & byte_ready_o.
  - Block transfer = block_valid_o & block_ready_i.
  - block_o, block_last_o and block_nbytes_o are stable while block_valid_o=1 and block_ready_i=0.
- State machine (count is 3 bits, 0..7):
  - FILL, byte_ready_o=1:
    - On a transfer, write byte_i into lane count (bits [63-8*count -: 8]) and increment count.
    - Transfer with count==7 and byte_last_i=0: go to OUT. Block = full buffer, last=0, nbytes=8.
    - Transfer with count==7 and byte_last_i=1: go to OUT. Block = full buffer, last=0, nbytes=8. Set pad_pending=1.
    - Transfer with count<7 and byte_last_i=1: go to OUT. Lane count+1 = PAD_BYTE, lanes above it zero, last=1, nbytes=count+1.
    - empty_i=1 with count==0 and byte_valid_i=0: go to OUT. Block = 64'h8000_0000_0000_0000, last=1, nbytes=0.
    - empty_i is ignored in all other cases. If byte_valid_i and empty_i are both high, the byte wins.
  - OUT, byte_ready_o=0, block_valid_o=1:
    - On a block transfer with pad_pending=1: go to PAD and clear pad_pending.
    - On a block transfer with pad_pending=0: go to FILL with count=0 and buffer cleared.
  - PAD, byte_ready_o=0, block_valid_o=1:
    - Block = 64'h8000_0000_0000_0000, last=1, nbytes=0.
    - On a block transfer: go to FILL.
- Latency:
  - block_valid_o rises in the cycle after the transfer of the byte that completes or terminates a block.
  - After a block transfer, byte_ready_o=1 in the next cycle. There is no overlap of fill and drain, so sustained throughput is 8 bytes per 9+ cycles.
- Unused lanes are always zero. block_o never contains stale bytes from a prior message.
- byte_last_i is ignored when byte_valid_i=0.

Decomposition:
- ascon_pack additions:
  - localparam ASCON_RATE_BYTES=8.
  - localparam ASCON_PAD_BYTE=8'h80.
  - typedef enum logic[1:0] {PK_FILL, PK_OUT, PK_PAD} packer_state_t.
- One combinational sub-module, ascon_pad_insert:
  - Inputs: buffer[63:0], count[2:0].
  - Output: buffer with PAD_BYTE placed at lane count and all higher-index lanes zeroed.
  - Reused later by the decrypt-path packer.

Test Plan:
- Reset then 3 bytes 0x11,0x22,0x33 (last on 0x33) -> one block 0x1122_3380_0000_0000, last=1, nbytes=3, valid 1 cycle after last byte.
- 8 bytes 0x01..0x08 (last on 0x08) -> block 0x0102030405060708 last=0 nbytes=8, then 0x8000000000000000 last=1 nbytes=0.
- 11 bytes 0xA0..0xAA -> block 0xA0A1..A7 last=0 nbytes=8, then 0xA8A9AA8000000000 last=1 nbytes=3.
- empty_i pulse from idle -> 0x8000000000000000 last=1 nbytes=0. Pulse during partial fill (count=2) -> ignored, no block.
- Hold block_ready_i=0 for 5 cycles -> block_o/last/nbytes stable, byte_ready_o=0, offered bytes not consumed.
- Assert resetb_i with 5 bytes buffered and again with block_valid_o=1 -> valid low next cycle. A following 1-byte message 0xFF yields 0xFF80000000000000 with no residue.
